// File: rtl/gpio_arb_pkg.sv
// Shared types and default sizing for the GPIO pad arbiter.
// Imported by the arbiter top and its round-robin picker.
package gpio_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } arb_state_e;

   localparam int DEF_GPIO_NUM = 32;
   localparam int DEF_NUM_REQ  = 4;
   localparam int DEF_HOLD_W   = 16;

endpackage

// File: rtl/gpio_rr_pick.sv
// Round-robin winner select: lowest requesting index at or
// after ptr, wrapping modulo N. Purely combinational.
module gpio_rr_pick
   import gpio_arb_pkg::*;
#(
   parameter int N = DEF_NUM_REQ
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 valid,
   output logic [$clog2(N)-1:0] index
);

   localparam int IW = $clog2(N);

   logic [IW:0] slot;

   // Walk offsets high to low so the nearest requester wins last.
   always_comb begin
      valid = |req;
      index = '0;
      slot  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         slot = {1'b0, ptr} + (IW + 1)'(k);
         if (slot >= (IW + 1)'(N)) begin
            slot = slot - (IW + 1)'(N);
         end
         if (req[slot[IW-1:0]]) begin
            index = slot[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/gpio_pad_arbiter.sv
// Hands GPIO pads to one hardware requester at a time,
// round-robin with an optional hold limit and a 1-cycle turnaround.
module gpio_pad_arbiter
   import gpio_arb_pkg::*;
#(
   parameter int GPIO_NUM = DEF_GPIO_NUM,
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int HOLD_W   = DEF_HOLD_W
) (
   input  logic                               pclk,
   input  logic                               prst,
   input  logic [NUM_REQ-1:0]                 req_i,
   input  logic [NUM_REQ-1:0]                 rel_i,
   input  logic [NUM_REQ-1:0][GPIO_NUM-1:0]   req_out_i,
   input  logic [NUM_REQ-1:0][GPIO_NUM-1:0]   req_dir_i,
   input  logic [GPIO_NUM-1:0]                sw_out_i,
   input  logic [GPIO_NUM-1:0]                sw_dir_i,
   input  logic [GPIO_NUM-1:0]                iof_i,
   input  logic [HOLD_W-1:0]                  hold_lim_i,
   output logic [NUM_REQ-1:0]                 gnt_o,
   output logic [$clog2(NUM_REQ)-1:0]         owner_o,
   output logic                               busy_o,
   output logic                               timeout_o,
   output logic [GPIO_NUM-1:0]                pad_out_o,
   output logic [GPIO_NUM-1:0]                pad_dir_o
);

   localparam int IW = $clog2(NUM_REQ);

   arb_state_e          state;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       owner;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [NUM_REQ-1:0]  gnt;
   logic                busy;
   logic                timeout;

   logic                pick_valid;
   logic [IW-1:0]       pick_idx;
   logic                own_rel;
   logic                own_drop;
   logic                lim_hit;
   logic                leave;
   logic [IW-1:0]       ptr_next;
   logic [GPIO_NUM-1:0] hw_sel;

   gpio_rr_pick #(
      .N (NUM_REQ)
   ) u_pick (
      .req   (req_i),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .index (pick_idx)
   );

   always_comb begin
      own_rel  = rel_i[owner];
      own_drop = ~req_i[owner];
      lim_hit  = (hold_lim_i != '0) &&
                 (hold_cnt == hold_lim_i - HOLD_W'(1));
      leave    = own_rel | own_drop | lim_hit;
      ptr_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         hold_cnt <= '0;
         gnt      <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         unique case (state)
            ST_IDLE, ST_TURN: begin
               if (pick_valid) begin
                  state    <= ST_GRANT;
                  owner    <= pick_idx;
                  gnt      <= NUM_REQ'(1) << pick_idx;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (leave) begin
                  state   <= ST_TURN;
                  gnt     <= '0;
                  busy    <= 1'b0;
                  rr_ptr  <= ptr_next;
                  // A release or drop in the same cycle is not a timeout.
                  timeout <= lim_hit & ~own_rel & ~own_drop;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               gnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign hw_sel    = iof_i & {GPIO_NUM{busy}};
   assign pad_out_o = (req_out_i[owner] & hw_sel) | (sw_out_i & ~hw_sel);
   assign pad_dir_o = (req_dir_i[owner] & hw_sel) | (sw_dir_i & ~hw_sel);

   assign gnt_o     = gnt;
   assign owner_o   = owner;
   assign busy_o    = busy;
   assign timeout_o = timeout;

endmodule

// File: doc/gpio_pad_arbiter.md
GPIO_PAD_ARBITER -- requirements
Module: gpio_pad_arbiter

Interface
REQ-001 SHALL have parameter GPIO_NUM, default 32, giving the pad count.
REQ-002 SHALL have parameter NUM_REQ, default 4, giving the number of hardware requesters (range 2..8).
REQ-003 SHALL have parameter HOLD_W, default 16, giving the hold-counter width.
REQ-004 SHALL have port pclk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port prst, input, 1, the reset: synchronous and active-high.
REQ-006 SHALL have port req_i, input, NUM_REQ, with one level request per requester.
REQ-007 SHALL have port rel_i, input, NUM_REQ, with one release pulse per requester.
REQ-008 SHALL have port req_out_i, input, NUM_REQ x GPIO_NUM, carrying per-requester pad output values.
REQ-009 SHALL have port req_dir_i, input, NUM_REQ x GPIO_NUM, carrying per-requester pad directions (1 = output).
REQ-010 SHALL have ports sw_out_i and sw_dir_i, input, GPIO_NUM each, carrying software pad out/dir from the APB GPIO core.
REQ-011 SHALL have port iof_i, input, GPIO_NUM, the pad ownership mask (1 = pad handed to the hardware owner).
REQ-012 SHALL have port hold_lim_i, input, HOLD_W, the maximum grant length in cycles; 0 disables the limit.
REQ-013 SHALL have port gnt_o, output, NUM_REQ, the one-hot registered grant.
REQ-014 SHALL have port owner_o, output, $clog2(NUM_REQ), the index of the current owner (valid while busy_o is high).
REQ-015 SHALL have port busy_o, output, 1, high while in GRANT.
REQ-016 SHALL have port timeout_o, output, 1, a one-cycle pulse when a grant is revoked by the limit.
REQ-017 SHALL have ports pad_out_o and pad_dir_o, output, GPIO_NUM each, the muxed pad drive.

Function
REQ-018 SHALL implement the FSM states IDLE, GRANT and TURN.
REQ-019 SHALL, in IDLE with req_i nonzero in cycle t, load the winner and enter GRANT so that gnt_o is high in cycle t+1.
REQ-020 SHALL select the winner as the lowest requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-021 SHALL clear hold_cnt on entry to GRANT and increment it by 1 each GRANT cycle, saturating at the all-ones value.
REQ-022 SHALL leave GRANT for TURN when rel_i[owner] is high, or req_i[owner] is low, or (hold_lim_i != 0 and hold_cnt == hold_lim_i-1), so that a grant lasts at most hold_lim_i cycles.
REQ-023 SHALL make release/drop take priority over the limit in the same cycle; timeout_o then stays low.
REQ-024 SHALL assert timeout_o only in the first TURN cycle entered through the limit.
REQ-025 SHALL ignore rel_i from non-owners and ignore req_i from non-owners while in GRANT; requests stay pending and are not latched.
REQ-026 SHALL set rr_ptr to (owner+1) mod NUM_REQ on GRANT exit.
REQ-027 SHALL make TURN last exactly 1 cycle with gnt_o=0, busy_o=0 and software drive on all pads.
REQ-028 SHALL, from TURN, arbitrate using the updated rr_ptr: go to GRANT if req_i is nonzero, else go to IDLE.
REQ-029 SHALL, per pad bit b, drive pad_out_o[b]/pad_dir_o[b] from req_out_i/req_dir_i[owner][b] when in GRANT and iof_i[b]=1, and from sw_out_i[b]/sw_dir_i[b] otherwise.
REQ-030 SHALL make the pad mux combinational from registered state, with zero added latency.
REQ-031 SHALL take an iof_i change during GRANT on the next pad evaluation, with no effect on the FSM.
REQ-032 SHALL keep gnt_o always one-hot or zero, and never assert more than one grant.

Reset
REQ-033 SHALL, while prst is high at a rising edge, set state=IDLE, rr_ptr=0, hold_cnt=0, owner=0, gnt_o=0, busy_o=0 and timeout_o=0.
REQ-034 SHALL, with reset asserted mid-GRANT, drop gnt_o at the next edge and drive pad_out_o/pad_dir_o from sw_out_i/sw_dir_i in that cycle.
REQ-035 SHALL, in the first cycle after reset release, arbitrate normally from IDLE with rr_ptr=0.

Structure
REQ-036 SHALL define the FSM state enum (IDLE, GRANT, TURN) and the default parameter constants in shared package gpio_arb_pkg.
REQ-037 SHALL place the round-robin winner selection in combinational sub-module gpio_rr_pick (inputs: req vector, ptr; outputs: valid, index).
REQ-038 SHALL keep all registers in gpio_pad_arbiter.

Verification
REQ-039 SHALL cover this scenario: req_i=4'b0110 from IDLE, rr_ptr=0 -> gnt_o=4'b0010 next cycle; rel_i[1] -> TURN, then gnt_o=4'b0100.
REQ-040 SHALL cover this scenario: hold_lim_i=5, req_i[0] held -> gnt_o[0] high exactly 5 cycles, timeout_o pulses once, owner 0 re-granted after TURN if it is alone.
REQ-041 SHALL cover this scenario: hold_lim_i=5, rel_i[0] on the 5th grant cycle -> TURN, timeout_o=0.
REQ-042 SHALL cover this scenario: iof_i=32'h0000_00FF, owner 2 with req_out_i[2]=32'hFFFF_FFFF, sw_out_i=0 -> pad_out_o=32'h0000_00FF; in TURN pad_out_o=0.
REQ-043 SHALL cover this scenario: all 4 requesting continuously with hold_lim_i=3 -> grant order 0,1,2,3,0, with a 1-cycle gap between each.
REQ-044 SHALL cover this scenario: prst pulsed during GRANT of owner 3 -> gnt_o=0 and pads follow sw_* in the next cycle, then a fresh grant starting from rr_ptr=0.
